// File: rtl/alu_pkg.sv
// Shared definitions for the 64-bit ALU and its two-requester arbiter:
// op codes, FSM state encoding and the registered response payload.
package alu_pkg;

   localparam int unsigned ALU_W = 64;
   localparam int unsigned OP_W  = 4;

   localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
   localparam logic [OP_W-1:0] OP_AND = 4'b0010;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
   localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
   localparam logic [OP_W-1:0] OP_SLL = 4'b0101;
   localparam logic [OP_W-1:0] OP_SRL = 4'b0110;
   localparam logic [OP_W-1:0] OP_SRA = 4'b0111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic [ALU_W-1:0] result;
      logic             zero;
      logic             src;
      logic             err;
   } rsp_t;

endpackage

// File: rtl/alu_64bit.sv
// Purely combinational shared ALU; illegal op codes give a zero result and err_c.
module alu_64bit
   import alu_pkg::*;
#(
   parameter int unsigned W = ALU_W
) (
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic [OP_W-1:0] op,
   output logic [W-1:0]    result_c,
   output logic            err_c
);

   localparam int unsigned SH_W = $clog2(W);

   logic [SH_W-1:0] sh;

   assign sh = b[SH_W-1:0];

   always_comb begin
      result_c = '0;
      err_c    = 1'b0;
      case (op)
         OP_ADD:  result_c = a + b;
         OP_SUB:  result_c = a - b;
         OP_AND:  result_c = a & b;
         OP_OR:   result_c = a | b;
         OP_XOR:  result_c = a ^ b;
         OP_SLL:  result_c = a << sh;
         OP_SRL:  result_c = a >> sh;
         OP_SRA:  result_c = W'($signed(a) >>> sh);
         default: err_c    = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared ALU,
// with a single registered response slot and 1 op/cycle throughput.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [OP_W-1:0]   req_op0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b1,
   input  logic [OP_W-1:0]   req_op1,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_src,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  gnt_cnt0,
   output logic [CNT_W-1:0]  gnt_cnt1
);

   state_e              state, state_nxt;
   rsp_t                rsp_q;
   logic                last_gnt;
   logic                win;
   logic                can_accept;
   logic                xfer;
   logic [DATA_W-1:0]   a_sel, b_sel, alu_res;
   logic [OP_W-1:0]     op_sel;
   logic                alu_err;
   logic [CNT_W-1:0]    cnt0_q, cnt1_q;

   // Winner: a lone requester wins outright; on contention the one not granted last.
   always_comb begin
      win = ~last_gnt;
      if (req_valid == 2'b01)      win = 1'b0;
      else if (req_valid == 2'b10) win = 1'b1;
   end

   assign can_accept = (state == ST_IDLE) | rsp_ready;
   assign req_ready  = (rst_n & can_accept & req_valid[win]) ?
                       (win ? 2'b10 : 2'b01) : 2'b00;
   assign xfer       = |(req_valid & req_ready);

   assign a_sel  = win ? req_a1  : req_a0;
   assign b_sel  = win ? req_b1  : req_b0;
   assign op_sel = win ? req_op1 : req_op0;

   alu_64bit #(.W(DATA_W)) u_alu (
      .a        (a_sel),
      .b        (b_sel),
      .op       (op_sel),
      .result_c (alu_res),
      .err_c    (alu_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // A new transfer always lands in BUSY; otherwise BUSY retires on rsp_ready.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (xfer) state_nxt = ST_BUSY;
         ST_BUSY: if (rsp_ready && !xfer) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_q    <= '0;
         last_gnt <= 1'b1;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
      end else if (xfer) begin
         rsp_q.result <= alu_res;
         rsp_q.zero   <= (alu_res == '0);
         rsp_q.src    <= win;
         rsp_q.err    <= alu_err;
         last_gnt     <= win;
         if (win) cnt1_q <= cnt1_q + CNT_W'(1);
         else     cnt0_q <= cnt0_q + CNT_W'(1);
      end
   end

   assign rsp_valid  = (state == ST_BUSY);
   assign rsp_result = rsp_q.result;
   assign rsp_zero   = rsp_q.zero;
   assign rsp_src    = rsp_q.src;
   assign rsp_err    = rsp_q.err;
   assign gnt_cnt0   = cnt0_q;
   assign gnt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of arbitration and the ALU.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a0, req_b0, req_a1, req_b1;
   logic [3:0]  req_op0, req_op1;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_result;
   logic        rsp_zero, rsp_src, rsp_err;
   logic [15:0] gnt_cnt0, gnt_cnt1;

   int vectors     = 0;
   int miscompares = 0;

   // model state
   bit          m_busy;
   logic [63:0] m_res;
   bit          m_zero, m_src, m_err, m_last;
   logic [15:0] m_cnt [2];

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(64), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
      .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_src(rsp_src), .rsp_err(rsp_err),
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] op, output bit err);
      int s;
      logic [63:0] ones;
      s    = int'(b % 64);
      ones = '1;
      err  = 1'b0;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << s;
         4'd6: return a >> s;
         4'd7: return (a >> s) | (a[63] ? ~(ones >> s) : 64'd0);
         default: begin err = 1'b1; return 64'd0; end
      endcase
   endfunction

   function automatic logic [1:0] exp_ready();
      if (!(!m_busy || rsp_ready) || req_valid == 2'b00) return 2'b00;
      if (req_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
      return req_valid;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_res = '0; m_zero = 0; m_src = 0; m_err = 0; m_last = 1;
      m_cnt[0] = '0; m_cnt[1] = '0;
   endtask

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic step(input logic [1:0] v, input logic rr, output logic [1:0] rdy_seen);
      logic [1:0]  er;
      logic [63:0] r;
      bit          e;
      int          w;
      req_valid = v;
      rsp_ready = rr;
      #1;
      er       = exp_ready();
      rdy_seen = req_ready;
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, m_busy);
      if (m_busy) begin
         chk("rsp_result", rsp_result, m_res);
         chk("rsp_zero", rsp_zero, m_zero);
         chk("rsp_src", rsp_src, m_src);
         chk("rsp_err", rsp_err, m_err);
      end
      chk("gnt_cnt0", gnt_cnt0, m_cnt[0]);
      chk("gnt_cnt1", gnt_cnt1, m_cnt[1]);
      @(posedge clk);
      if (er != 2'b00) begin
         w = er[1] ? 1 : 0;
         r = (w == 1) ? ref_alu(req_a1, req_b1, req_op1, e) : ref_alu(req_a0, req_b0, req_op0, e);
         m_res  = r;
         m_err  = e;
         m_zero = (r == 64'd0);
         m_src  = (w == 1);
         m_last = (w == 1);
         m_cnt[w] = m_cnt[w] + 16'd1;
         m_busy = 1;
      end else if (m_busy && rr) begin
         m_busy = 0;
      end
      @(negedge clk);
   endtask

   // Assert reset (called at a negedge), check the asynchronous effect, release.
   task automatic do_reset();
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      rst_n     = 1'b0;
      #1;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_result", rsp_result, 64'd0);
      chk("rst_flags", {rsp_zero, rsp_src, rsp_err}, 3'b000);
      chk("rst_cnt", {gnt_cnt1, gnt_cnt0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   function automatic logic [63:0] rnd_opnd();
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) return 64'd0;
      if (sel == 1) return '1;
      return {$urandom, $urandom};
   endfunction

   function automatic logic [3:0] rnd_op();
      if ($urandom_range(0, 9) == 0) return 4'($urandom_range(8, 15));
      return 4'($urandom_range(0, 7));
   endfunction

   initial begin
      logic [1:0] rdy;
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      req_op0 = OP_ADD; req_op1 = OP_ADD;
      model_reset();
      @(negedge clk);
      do_reset();

      // single request, 1-cycle latency
      req_a0 = 64'd5; req_b0 = 64'd3; req_op0 = OP_ADD;
      step(2'b01, 1'b0, rdy);
      chk("lit_ready01", rdy, 2'b01);
      chk("lit_add_valid", rsp_valid, 1'b1);
      chk("lit_add_result", rsp_result, 64'd8);
      chk("lit_add_flags", {rsp_zero, rsp_src, rsp_err}, 3'b000);
      chk("lit_add_cnt0", gnt_cnt0, 16'd1);

      // round-robin under continuous contention
      do_reset();
      req_a0 = 64'd1; req_b0 = 64'd1; req_a1 = 64'd2; req_b1 = 64'd2;
      for (int k = 0; k < 4; k++) begin
         step(2'b11, 1'b1, rdy);
         chk("lit_rr_grant", rdy, (k % 2 == 1) ? 2'b10 : 2'b01);
         chk("lit_rr_src", rsp_src, (k % 2 == 1) ? 1'b1 : 1'b0);
      end
      chk("lit_rr_cnts", {gnt_cnt1, gnt_cnt0}, {16'd2, 16'd2});

      // back-pressure holds the response and blocks requester 1
      for (int k = 0; k < 3; k++) begin
         step(2'b10, 1'b0, rdy);
         chk("lit_stall_ready", rdy, 2'b00);
      end
      step(2'b10, 1'b1, rdy);
      chk("lit_release_ready", rdy, 2'b10);
      chk("lit_release_cnt1", gnt_cnt1, 16'd3);

      // SUB to zero, then an illegal op
      req_a0 = '1; req_b0 = '1; req_op0 = OP_SUB;
      step(2'b01, 1'b1, rdy);
      chk("lit_sub_result", rsp_result, 64'd0);
      chk("lit_sub_flags", {rsp_zero, rsp_err}, 2'b10);
      req_op0 = 4'b1010;
      step(2'b01, 1'b1, rdy);
      chk("lit_illegal_result", rsp_result, 64'd0);
      chk("lit_illegal_flags", {rsp_zero, rsp_err}, 2'b11);

      // arithmetic shift of the sign bit all the way down
      req_a1 = 64'h8000_0000_0000_0000; req_b1 = 64'd63; req_op1 = OP_SRA;
      step(2'b10, 1'b1, rdy);
      chk("lit_sra_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("lit_sra_zero", rsp_zero, 1'b0);

      // reset while BUSY, then first contention goes to requester 0
      chk("lit_busy_before_rst", rsp_valid, 1'b1);
      do_reset();
      step(2'b11, 1'b1, rdy);
      chk("lit_post_rst_grant", rdy, 2'b01);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         req_a0 = rnd_opnd(); req_b0 = rnd_opnd(); req_op0 = rnd_op();
         req_a1 = rnd_opnd(); req_b1 = rnd_opnd(); req_op1 = rnd_op();
         if ($urandom_range(0, 249) == 0) do_reset();
         step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), rdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
